// File: rtl/mips_register_file.sv
// 32-entry MIPS register file: two async read ports, one sync write port, debug read port.
// Define MIPS_RF_WRITE_BYPASS_EN to forward write_data to the read ports in the write cycle.
module mips_register_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reg_write,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  input  logic [ADDR_WIDTH-1:0] dbg_reg,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam int unsigned NumRegs = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NumRegs];
  logic [DATA_WIDTH-1:0] regs_d [NumRegs];
  logic                  wr_en;

  assign wr_en = reg_write && (write_reg != '0);

  // Entry 0 is forced to zero so every read port returns 0 for $0 without extra muxing.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[write_reg] = write_data;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

`ifdef MIPS_RF_WRITE_BYPASS_EN
  logic hit1, hit2;

  assign hit1 = rst_n && wr_en && (read_reg1 == write_reg);
  assign hit2 = rst_n && wr_en && (read_reg2 == write_reg);

  always_comb begin
    read_data1 = hit1 ? write_data : regs_q[read_reg1];
    read_data2 = hit2 ? write_data : regs_q[read_reg2];
  end
`else
  always_comb begin
    read_data1 = regs_q[read_reg1];
    read_data2 = regs_q[read_reg2];
  end
`endif

  assign dbg_data = regs_q[dbg_reg];

endmodule

// File: tb/tb_mips_register_file.sv
// Self-checking bench for mips_register_file: reference array model feeding a scoreboard queue.
module tb_mips_register_file;

  logic        clk;
  logic        rst_n;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [4:0]  dbg_reg;
  logic [31:0] dbg_data;

  mips_register_file #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .reg_write (reg_write),
    .write_reg (write_reg),
    .write_data(write_data),
    .read_reg1 (read_reg1),
    .read_reg2 (read_reg2),
    .read_data1(read_data1),
    .read_data2(read_data2),
    .dbg_reg   (dbg_reg),
    .dbg_data  (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model [32];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int port, input logic [31:0] exp);
    exp_t e;
    e.tag  = tag;
    e.port = port;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain_sb();
    exp_t        e;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.port)
        0:       obs = read_data1;
        1:       obs = read_data2;
        default: obs = dbg_data;
      endcase
      check_eq(e.tag, obs, e.exp);
    end
  endtask

  // Set all three read indices, push model expectations, sample away from the clock edge.
  task automatic probe(input string tag, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] d);
    @(negedge clk);
    read_reg1 = r1;
    read_reg2 = r2;
    dbg_reg   = d;
    #1;
    push_exp({tag, ".rd1"}, 0, model[r1]);
    push_exp({tag, ".rd2"}, 1, model[r2]);
    push_exp({tag, ".dbg"}, 2, model[d]);
    drain_sb();
  endtask

  task automatic do_write(input logic we, input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    reg_write  = we;
    write_reg  = addr;
    write_data = data;
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    if (we && addr != 5'd0 && rst_n) model[addr] = data;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  initial begin
    logic [4:0]  ra;
    logic [31:0] rd;
    clear_model();
    rst_n      = 1'b0;
    reg_write  = 1'b0;
    write_reg  = '0;
    write_data = '0;
    read_reg1  = 5'd1;
    read_reg2  = 5'd31;
    dbg_reg    = 5'd16;

    probe("reset_state", 5'd1, 5'd31, 5'd16);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write/read
    do_write(1'b1, 5'd8, 32'h1234_5678);
    do_write(1'b1, 5'd31, 32'hFFFF_FFFF);
    probe("basic", 5'd8, 5'd31, 5'd8);
    check_eq("basic_rd1_const", read_data1, 32'h1234_5678);
    check_eq("basic_rd2_const", read_data2, 32'hFFFF_FFFF);

    // Zero register
    do_write(1'b1, 5'd0, 32'hAAAA_5555);
    probe("zero_reg", 5'd0, 5'd0, 5'd0);
    for (int i = 1; i < 32; i++) probe("zero_sweep", 5'd0, 5'd8, 5'(i));

    // Write enable low
    do_write(1'b1, 5'd9, 32'h0000_0001);
    for (int i = 0; i < 3; i++) do_write(1'b0, 5'd9, 32'hCAFE_F00D);
    probe("we_low", 5'd9, 5'd9, 5'd9);
    check_eq("we_low_const", dbg_data, 32'h0000_0001);

    // Collision: pre-edge value depends on bypass build; debug port never bypassed
    do_write(1'b1, 5'd4, 32'h0000_0011);
    @(negedge clk);
    reg_write  = 1'b1;
    write_reg  = 5'd4;
    write_data = 32'h0000_0022;
    read_reg1  = 5'd4;
    read_reg2  = 5'd4;
    dbg_reg    = 5'd4;
    #1;
`ifdef MIPS_RF_WRITE_BYPASS_EN
    push_exp("collide_pre.rd1", 0, 32'h0000_0022);
    push_exp("collide_pre.rd2", 1, 32'h0000_0022);
`else
    push_exp("collide_pre.rd1", 0, 32'h0000_0011);
    push_exp("collide_pre.rd2", 1, 32'h0000_0011);
`endif
    push_exp("collide_pre.dbg", 2, 32'h0000_0011);
    drain_sb();
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    model[4]  = 32'h0000_0022;
    push_exp("collide_post.rd1", 0, 32'h0000_0022);
    push_exp("collide_post.dbg", 2, 32'h0000_0022);
    drain_sb();

    // Same index on all three ports
    do_write(1'b1, 5'd17, 32'h00C0_FFEE);
    probe("same_idx", 5'd17, 5'd17, 5'd17);

    // Random writes against the model
    for (int i = 0; i < 40; i++) begin
      ra = 5'($urandom_range(0, 31));
      rd = $urandom;
      do_write(1'b1, ra, rd);
      probe("rand", ra, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    // Asynchronous reset mid-cycle
    do_write(1'b1, 5'd5, 32'hDEAD_BEEF);
    @(negedge clk);
    read_reg1 = 5'd5;
    #1;
    push_exp("pre_reset.rd1", 0, 32'hDEAD_BEEF);
    drain_sb();
    #1;
    rst_n = 1'b0;
    #1;
    push_exp("async_reset.rd1", 0, 32'h0);
    drain_sb();
    clear_model();
    // Write attempted across an edge while in reset must be dropped
    reg_write  = 1'b1;
    write_reg  = 5'd6;
    write_data = 32'h1234_0006;
    read_reg2  = 5'd6;
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    push_exp("reset_write_drop.rd2", 1, 32'h0);
    drain_sb();
    @(negedge clk);
    rst_n = 1'b1;
    probe("post_reset", 5'd5, 5'd6, 5'd31);
    do_write(1'b1, 5'd5, 32'h0BAD_F00D);
    probe("post_reset_write", 5'd5, 5'd8, 5'd5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
